// File: rtl/scr1_tcm_loader.sv
`timescale 1ns/1ps
// scr1_tcm_loader: boot loader that writes a length-prefixed little-endian byte stream into TCM port B.
// Define SCR1_TCM_LOADER_VERIFY_EN to add a checksum readback pass before the core is released.
module scr1_tcm_loader #(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 32'h00010000,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter int AW          = $clog2(SCR1_SIZE) - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_renb,
    output logic                   mem_wenb,
    output logic [SCR1_NBYTES-1:0] mem_webb,
    output logic [AW-1:0]          mem_addrb,
    output logic [SCR1_WIDTH-1:0]  mem_datab,
    input  logic [SCR1_WIDTH-1:0]  mem_qb,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam logic [31:0] MAX_WORDS = 32'(SCR1_SIZE / 4);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_WLAST,
        ST_VRD,
        ST_VCMP,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                  state_reg;
    logic [1:0]              bcnt_reg;
    logic [31:0]             n_reg;
    logic [AW:0]             wcnt_reg;
    logic                    in_ready_reg;
    logic                    mem_wenb_reg;
    logic [SCR1_NBYTES-1:0]  mem_webb_reg;
    logic [AW-1:0]           mem_addrb_reg;
    logic [SCR1_WIDTH-1:0]   mem_datab_reg;
    logic                    core_rst_n_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [1:0]              err_code_reg;

    logic                    accept;
    logic [31:0]             word_full;

    assign accept = in_valid && in_ready_reg;

    // Lanes 0..2 of the word being assembled; lane 3 is taken straight from in_data.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    lane_reg <= '0;
                end else if (accept && (bcnt_reg == 2'(gi))) begin
                    lane_reg <= in_data;
                end
            end
        end
    endgenerate

    assign word_full = {in_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

`ifdef SCR1_TCM_LOADER_VERIFY_EN
    logic                    mem_renb_reg;
    logic                    rd_valid_reg;
    logic [AW:0]             rcnt_reg;
    logic [31:0]             s_sum_reg;
    logic [31:0]             r_sum_reg;
    logic [31:0]             r_final;

    // Running readback sum including the word currently on mem_qb.
    assign r_final  = r_sum_reg + mem_qb;
    assign mem_renb = mem_renb_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            r_sum_reg    <= '0;
        end else begin
            rd_valid_reg <= mem_renb_reg;
            if (rd_valid_reg) begin
                r_sum_reg <= r_final;
            end
        end
    end
`else
    logic unused_qb;
    assign unused_qb = ^mem_qb;
    assign mem_renb  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_LEN;
            bcnt_reg       <= '0;
            n_reg          <= '0;
            wcnt_reg       <= '0;
            in_ready_reg   <= 1'b0;
            mem_wenb_reg   <= 1'b0;
            mem_webb_reg   <= '0;
            mem_addrb_reg  <= '0;
            mem_datab_reg  <= '0;
            core_rst_n_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= 2'd0;
`ifdef SCR1_TCM_LOADER_VERIFY_EN
            mem_renb_reg   <= 1'b0;
            rcnt_reg       <= '0;
            s_sum_reg      <= '0;
`endif
        end else begin
            mem_wenb_reg <= 1'b0;
            mem_webb_reg <= '0;
            case (state_reg)
                ST_LEN: begin
                    in_ready_reg <= 1'b1;
                    busy_reg     <= 1'b1;
                    if (accept) begin
                        bcnt_reg <= bcnt_reg + 2'd1;
                        if (bcnt_reg == 2'd3) begin
                            n_reg    <= word_full;
                            wcnt_reg <= '0;
                            if (word_full == 32'd0) begin
                                state_reg      <= ST_DONE;
                                in_ready_reg   <= 1'b0;
                                busy_reg       <= 1'b0;
                                done_reg       <= 1'b1;
                                core_rst_n_reg <= 1'b1;
                            end else if (word_full > MAX_WORDS) begin
                                state_reg    <= ST_ERR;
                                in_ready_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                                err_reg      <= 1'b1;
                                err_code_reg <= 2'd1;
                            end else begin
                                state_reg <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        bcnt_reg <= bcnt_reg + 2'd1;
                        if (bcnt_reg == 2'd3) begin
                            mem_wenb_reg  <= 1'b1;
                            mem_webb_reg  <= '1;
                            mem_addrb_reg <= wcnt_reg[AW-1:0];
                            mem_datab_reg <= word_full;
                            wcnt_reg      <= wcnt_reg + 1'b1;
`ifdef SCR1_TCM_LOADER_VERIFY_EN
                            s_sum_reg     <= s_sum_reg + word_full;
`endif
                            // Stop taking bytes as soon as the last word is in hand.
                            if (32'(wcnt_reg) + 32'd1 == n_reg) begin
                                in_ready_reg <= 1'b0;
                                state_reg    <= ST_WLAST;
                            end
                        end
                    end
                end
                ST_WLAST: begin
`ifdef SCR1_TCM_LOADER_VERIFY_EN
                    state_reg     <= ST_VRD;
                    mem_renb_reg  <= 1'b1;
                    mem_addrb_reg <= '0;
                    rcnt_reg      <= {{AW{1'b0}}, 1'b1};
`else
                    state_reg      <= ST_DONE;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b1;
                    core_rst_n_reg <= 1'b1;
`endif
                end
`ifdef SCR1_TCM_LOADER_VERIFY_EN
                ST_VRD: begin
                    if (32'(rcnt_reg) < n_reg) begin
                        mem_addrb_reg <= rcnt_reg[AW-1:0];
                        rcnt_reg      <= rcnt_reg + 1'b1;
                    end else begin
                        mem_renb_reg <= 1'b0;
                        state_reg    <= ST_VCMP;
                    end
                end
                ST_VCMP: begin
                    busy_reg <= 1'b0;
                    if (r_final == s_sum_reg) begin
                        state_reg      <= ST_DONE;
                        done_reg       <= 1'b1;
                        core_rst_n_reg <= 1'b1;
                    end else begin
                        state_reg    <= ST_ERR;
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'd2;
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state_reg <= ST_LEN;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign mem_wenb   = mem_wenb_reg;
    assign mem_webb   = mem_webb_reg;
    assign mem_addrb  = mem_addrb_reg;
    assign mem_datab  = mem_datab_reg;
    assign core_rst_n = core_rst_n_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_scr1_tcm_loader.sv
`timescale 1ns/1ps
// Directed/randomized bench for scr1_tcm_loader with a TCM port-B model and a load-level reference model.
module tb_scr1_tcm_loader;

    localparam int SIZE = 32'h00010000;
    localparam int AW   = $clog2(SIZE) - 2;
    localparam int NW   = SIZE / 4;
`ifdef SCR1_TCM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          mem_renb;
    logic          mem_wenb;
    logic [3:0]    mem_webb;
    logic [AW-1:0] mem_addrb;
    logic [31:0]   mem_datab;
    logic [31:0]   mem_qb;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int tests = 0;
    int fails = 0;

    scr1_tcm_loader #(
        .SCR1_WIDTH (32),
        .SCR1_SIZE  (SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_renb   (mem_renb),
        .mem_wenb   (mem_wenb),
        .mem_webb   (mem_webb),
        .mem_addrb  (mem_addrb),
        .mem_datab  (mem_datab),
        .mem_qb     (mem_qb),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // TCM port B model: byte-enabled writes, 1-cycle read latency, optional bit flip on word 1.
    logic [31:0] tcm [0:NW-1];
    bit          flip_en = 1'b0;
    always @(posedge clk) begin
        if (mem_wenb) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_webb[b]) tcm[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
            end
        end
        if (mem_renb) mem_qb <= tcm[mem_addrb] ^ ((flip_en && mem_addrb == 1) ? 32'h1 : 32'h0);
    end

    // Monitor: cycle-stamped log of accepted bytes, writes and done/err rising edges.
    int          cyc      = 0;
    int          both_cnt = 0;
    logic        end_prev = 1'b0;
    int          acc_q[$];
    int          end_q[$];
    int          wr_cyc_q[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];
    always @(posedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (mem_wenb) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(mem_addrb));
            wr_data_q.push_back(mem_datab);
            wr_be_q.push_back(mem_webb);
        end
        if ((done || err) && !end_prev) end_q.push_back(cyc);
        if (mem_wenb && mem_renb) both_cnt <= both_cnt + 1;
        end_prev <= done || err;
        cyc      <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_renb", 64'(mem_renb), 64'd0);
        check("rst_mem_wenb", 64'(mem_wenb), 64'd0);
        check("rst_mem_webb", 64'(mem_webb), 64'd0);
        check("rst_mem_addrb", 64'(mem_addrb), 64'd0);
        check("rst_mem_datab", 64'(mem_datab), 64'd0);
        check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (!in_ready && tries < 64) begin
            @(negedge clk);
            tries++;
        end
        check("byte_accept_timeout", 64'(tries < 64), 64'd1);
    endtask

    logic [31:0] img[$];

    task automatic send_words(input int nwords, input int maxgap);
        logic [31:0] w;
        for (int i = 0; i < nwords; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
        end
    endtask

    // Full load of header hdr plus img, followed by extra bytes that must be refused.
    task automatic run_load(input logic [31:0] hdr, input int maxgap, input int extra, input bit flip);
        int          base_acc, base_wr, base_end, base_both;
        int          exp_n, exp_acc, lat, tries, nacc, nwr;
        logic [31:0] s_ref, r_ref;
        bit          exp_done;
        logic [1:0]  exp_code;

        base_acc  = acc_q.size();
        base_wr   = wr_addr_q.size();
        base_end  = end_q.size();
        base_both = both_cnt;
        flip_en   = flip;

        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], $urandom_range(0, maxgap));
        exp_n = (hdr <= 32'(NW)) ? int'(hdr) : 0;
        send_words(exp_n, maxgap);
        for (int k = 0; k < extra; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        tries = 0;
        while (!(done || err) && tries < 400) begin
            @(negedge clk);
            tries++;
        end
        check("end_timeout", 64'(tries < 400), 64'd1);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;

        // Reference: checksums and outcome derived from the image and the load rules.
        s_ref = 32'd0;
        r_ref = 32'd0;
        for (int i = 0; i < exp_n; i++) begin
            s_ref += img[i];
            r_ref += img[i] ^ ((flip && i == 1) ? 32'h1 : 32'h0);
        end
        exp_acc = 4 + 4 * exp_n;
        if (hdr > 32'(NW)) begin
            exp_done = 1'b0; exp_code = 2'd1; lat = 1;
        end else if (exp_n == 0) begin
            exp_done = 1'b1; exp_code = 2'd0; lat = 1;
        end else if (VERIFY && s_ref != r_ref) begin
            exp_done = 1'b0; exp_code = 2'd2; lat = 2 + exp_n + 1;
        end else begin
            exp_done = 1'b1; exp_code = 2'd0; lat = VERIFY ? 2 + exp_n + 1 : 2;
        end

        nacc = acc_q.size() - base_acc;
        nwr  = wr_addr_q.size() - base_wr;
        check("accepted_bytes", 64'(nacc), 64'(exp_acc));
        check("write_count", 64'(nwr), 64'(exp_n));
        if (nacc == exp_acc && nwr == exp_n) begin
            for (int i = 0; i < exp_n; i++) begin
                check($sformatf("wr_addr[%0d]", i), 64'(wr_addr_q[base_wr+i]), 64'(i));
                check($sformatf("wr_data[%0d]", i), 64'(wr_data_q[base_wr+i]), 64'(img[i]));
                check($sformatf("wr_be[%0d]", i), 64'(wr_be_q[base_wr+i]), 64'hF);
                check($sformatf("wr_lag[%0d]", i),
                      64'(wr_cyc_q[base_wr+i] - acc_q[base_acc+4*i+7]), 64'd1);
                check($sformatf("tcm[%0d]", i), 64'(tcm[i]), 64'(img[i]));
            end
            if (end_q.size() > base_end) begin
                check("end_latency", 64'(end_q[base_end] - acc_q[base_acc+exp_acc-1]), 64'(lat));
            end
        end
        check("end_events", 64'(end_q.size() - base_end), 64'd1);
        check("done", 64'(done), 64'(exp_done));
        check("err", 64'(err), 64'(!exp_done));
        check("err_code", 64'(err_code), 64'(exp_code));
        check("core_rst_n", 64'(core_rst_n), 64'(exp_done));
        check("end_in_ready", 64'(in_ready), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_strobes", 64'({mem_wenb, mem_renb}), 64'd0);
        check("wenb_renb_overlap", 64'(both_cnt - base_both), 64'd0);
        $display("[TB] load hdr=0x%08h words=%0d gap<=%0d extra=%0d flip=%0b -> done=%0b err=%0b code=%0d",
                 hdr, exp_n, maxgap, extra, flip, done, err, err_code);
        flip_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);
        check("first_in_ready", 64'(in_ready), 64'd1);
        check("first_busy", 64'(busy), 64'd1);

        img = '{32'h01402603, 32'h00167613, 32'hfe060ce3};
        run_load(32'd3, 0, 0, 1'b0);

        pulse_reset();
        run_load(32'd0, 0, 2, 1'b0);

        pulse_reset();
        run_load(32'h00004001, 0, 3, 1'b0);

        pulse_reset();
        run_load(32'hFFFFFFFF, 2, 1, 1'b0);

        pulse_reset();
        img = '{32'h01402603, 32'h00167613, 32'hfe060ce3};
        run_load(32'd3, 5, 4, 1'b0);

        pulse_reset();
        run_load(32'd3, 1, 2, 1'b1);

        // Abort after two of three words, then reload from scratch.
        pulse_reset();
        for (int k = 0; k < 4; k++) send_byte(8'(32'd3 >> (8 * k)), 0);
        send_words(2, 0);
        pulse_reset();
        run_load(32'd3, 2, 2, 1'b0);

        for (int r = 0; r < 3; r++) begin
            pulse_reset();
            n = $urandom_range(1, 6);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_load(32'(n), 3, 2, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
